hilo_mult_unit: RTL

//  Iterative shift-add multiplier that owns the architectural HI/LO register pair.

---
 rtl/hilo_mult_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/hilo_mult_unit.sv
// hilo_mult_unit: iterative shift-add multiplier owning HI/LO.
// Optional signed MULT semantics via `define HILO_SIGNED_EN.
module hilo_mult_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       hilo_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_p;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_p_nxt;
  logic [2*WIDTH-1:0] w_res;

  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_state == S_RUN) &&
                    (r_cnt == CNT_W'(WIDTH - 1));

  // one shift-add step: conditional add into the upper half, then shift
  always_comb begin
    w_addend = '0;
    if (r_p[0])
      w_addend = {1'b0, r_mcand};
    w_sum   = {1'b0, r_p[2*WIDTH-1:WIDTH]} + w_addend;
    w_p_nxt = {w_sum, r_p[WIDTH-1:1]};
  end

`ifdef HILO_SIGNED_EN
  logic r_sign;
  logic w_sign_in;

  // magnitudes go through the unsigned core; sign is fixed up at the end
  always_comb begin
    w_a_mag   = a[WIDTH-1] ? -a : a;
    w_b_mag   = b[WIDTH-1] ? -b : b;
    w_sign_in = a[WIDTH-1] ^ b[WIDTH-1];
    w_res     = r_sign ? -w_p_nxt : w_p_nxt;
  end

  // sign of the in-flight product, captured with the operands
  always_ff @(posedge clk) begin
    if (!rst)
      r_sign <= 1'b0;
    else if (w_accept)
      r_sign <= w_sign_in;
  end
`else
  // unsigned operands feed the core directly
  always_comb begin
    w_a_mag = a;
    w_b_mag = b;
    w_res   = w_p_nxt;
  end
`endif

  // state register
  always_ff @(posedge clk) begin
    if (!rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // next-state and status outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = start ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last)
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = start ? S_RUN : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // operand latch, iteration and HI/LO write-back
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mcand <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (w_accept) begin
      r_mcand <= w_a_mag;
      r_p     <= {{WIDTH{1'b0}}, w_b_mag};
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_p   <= w_p_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_hi <= w_res[2*WIDTH-1:WIDTH];
        r_lo <= w_res[WIDTH-1:0];
      end
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

  // MFHI/MFLO read mux; no bypass of the in-flight product
  always_comb begin
    rd_data = '0;
    case (hilo_sel)
      2'b10:   rd_data = r_hi;
      2'b01:   rd_data = r_lo;
      default: rd_data = '0;
    endcase
  end

endmodule
